// File: rtl/dma_ahb_master.sv
// Single-channel DMA burst engine driving an AHB-Lite master port.
// INCR bursts of up to 31 beats, split to NONSEQ at 1 KB boundaries.
module dma_ahb_master (
  input  logic        I_DMA_HCLK,
  input  logic        I_DMA_HRESET_N,
  input  logic        I_DMA_START,
  input  logic [31:0] I_DMA_ADDR,
  input  logic        I_DMA_WRITE,
  input  logic [4:0]  I_DMA_COUNT,
  input  logic [2:0]  I_DMA_SIZE,
  output logic        O_DMA_READY,
  output logic        O_DMA_DONE,
  output logic        O_DMA_ERROR,
  input  logic [31:0] I_DMA_WDATA,
  output logic        O_DMA_WDATA_REQ,
  output logic [31:0] O_DMA_RDATA,
  output logic        O_DMA_RDATA_VALID,
  output logic [31:0] O_HADDR,
  output logic [1:0]  O_HTRANS,
  output logic        O_HWRITE,
  output logic [2:0]  O_HSIZE,
  output logic [2:0]  O_HBURST,
  output logic [31:0] O_HWDATA,
  input  logic [31:0] I_HRDATA,
  input  logic        I_HREADY,
  input  logic        I_HRESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_BURST,
    S_LAST,
    S_ERR
  } state_e;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [4:0]  count_q, count_d;
  logic [4:0]  issued_q, issued_d;
  logic [4:0]  compl_q, compl_d;
  logic        dph_q, dph_d;

  logic        addr_ok;
  logic        data_ok;
  logic        data_err;
  logic [31:0] next_addr;

  assign addr_ok   = (htrans_q != HT_IDLE) && I_HREADY;
  assign data_ok   = dph_q && I_HREADY && !I_HRESP;
  assign data_err  = dph_q && I_HRESP;
  assign next_addr = haddr_q + (32'd1 << hsize_q);

  assign O_DMA_READY       = (state_q == S_IDLE);
  assign O_DMA_DONE        = done_q;
  assign O_DMA_ERROR       = error_q;
  assign O_DMA_WDATA_REQ   = addr_ok && hwrite_q && !data_err;
  assign O_DMA_RDATA       = rdata_q;
  assign O_DMA_RDATA_VALID = rvalid_q;
  assign O_HADDR           = haddr_q;
  assign O_HTRANS          = htrans_q;
  assign O_HWRITE          = hwrite_q;
  assign O_HSIZE           = hsize_q;
  assign O_HBURST          = 3'b001;
  assign O_HWDATA          = hwdata_q;

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    error_d  = 1'b0;
    count_d  = count_q;
    issued_d = issued_q;
    compl_d  = compl_q;
    dph_d    = dph_q;

    if (addr_ok) begin
      issued_d = issued_q + 5'd1;
      if (hwrite_q && !data_err) hwdata_d = I_DMA_WDATA;
    end
    if (data_ok) compl_d = compl_q + 5'd1;
    if (data_ok && !hwrite_q && state_q != S_ERR) begin
      rdata_d  = I_HRDATA;
      rvalid_d = 1'b1;
    end
    // a data phase ends on HREADY; the next one exists only if an address phase completed
    if (I_HREADY) dph_d = addr_ok;

    unique case (state_q)
      S_IDLE: begin
        if (I_DMA_START) begin
          if (I_DMA_SIZE > 3'd2) begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end else if (I_DMA_COUNT == 5'd0) begin
            done_d = 1'b1;
          end else begin
            count_d  = I_DMA_COUNT;
            haddr_d  = I_DMA_ADDR;
            hwrite_d = I_DMA_WRITE;
            hsize_d  = I_DMA_SIZE;
            htrans_d = HT_NONSEQ;
            issued_d = 5'd0;
            compl_d  = 5'd0;
            state_d  = S_ADDR;
          end
        end
      end
      S_ADDR, S_BURST, S_LAST: begin
        if (data_err) begin
          htrans_d = HT_IDLE;
          if (I_HREADY) begin
            dph_d   = 1'b0;
            done_d  = 1'b1;
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ERR;
          end
        end else if (state_q == S_LAST) begin
          if (data_ok && compl_d == count_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (addr_ok) begin
          if (issued_d == count_q) begin
            htrans_d = HT_IDLE;
            state_d  = S_LAST;
          end else begin
            haddr_d  = next_addr;
            // restart with NONSEQ when crossing a 1 KB page
            htrans_d = (next_addr[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
            state_d  = S_BURST;
          end
        end
      end
      S_ERR: begin
        htrans_d = HT_IDLE;
        if (I_HREADY) begin
          dph_d   = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_DMA_HCLK or negedge I_DMA_HRESET_N) begin
    if (!I_DMA_HRESET_N) begin
      state_q  <= S_IDLE;
      haddr_q  <= 32'h0;
      htrans_q <= HT_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'h2;
      hwdata_q <= 32'h0;
      rdata_q  <= 32'h0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      count_q  <= 5'd0;
      issued_q <= 5'd0;
      compl_q  <= 5'd0;
      dph_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      error_q  <= error_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      compl_q  <= compl_d;
      dph_q    <= dph_d;
    end
  end

endmodule

// File: tb/tb_dma_ahb_master.sv
// Directed bench for dma_ahb_master with a small AHB slave model.
// Slave inserts waits/errors on a chosen beat; monitor logs beats.
module tb_dma_ahb_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        I_DMA_START = 1'b0;
  logic [31:0] I_DMA_ADDR = 32'h0;
  logic        I_DMA_WRITE = 1'b0;
  logic [4:0]  I_DMA_COUNT = 5'd0;
  logic [2:0]  I_DMA_SIZE = 3'd2;
  logic [31:0] I_DMA_WDATA = 32'h0;
  logic [31:0] I_HRDATA = 32'h0;
  logic        I_HREADY = 1'b1;
  logic        I_HRESP = 1'b0;
  logic        O_DMA_READY, O_DMA_DONE, O_DMA_ERROR;
  logic        O_DMA_WDATA_REQ, O_DMA_RDATA_VALID;
  logic [31:0] O_DMA_RDATA, O_HADDR, O_HWDATA;
  logic [1:0]  O_HTRANS;
  logic        O_HWRITE;
  logic [2:0]  O_HSIZE, O_HBURST;

  dma_ahb_master dut (
    .I_DMA_HCLK(clk),
    .I_DMA_HRESET_N(rst_n),
    .I_DMA_START(I_DMA_START),
    .I_DMA_ADDR(I_DMA_ADDR),
    .I_DMA_WRITE(I_DMA_WRITE),
    .I_DMA_COUNT(I_DMA_COUNT),
    .I_DMA_SIZE(I_DMA_SIZE),
    .O_DMA_READY(O_DMA_READY),
    .O_DMA_DONE(O_DMA_DONE),
    .O_DMA_ERROR(O_DMA_ERROR),
    .I_DMA_WDATA(I_DMA_WDATA),
    .O_DMA_WDATA_REQ(O_DMA_WDATA_REQ),
    .O_DMA_RDATA(O_DMA_RDATA),
    .O_DMA_RDATA_VALID(O_DMA_RDATA_VALID),
    .O_HADDR(O_HADDR),
    .O_HTRANS(O_HTRANS),
    .O_HWRITE(O_HWRITE),
    .O_HSIZE(O_HSIZE),
    .O_HBURST(O_HBURST),
    .O_HWDATA(O_HWDATA),
    .I_HRDATA(I_HRDATA),
    .I_HREADY(I_HREADY),
    .I_HRESP(I_HRESP)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  logic [31:0] q_addr[$];
  logic [1:0]  q_tr[$];
  logic [31:0] q_wd[$];
  logic [31:0] q_rd[$];
  int nacc, nwreq, ndone, nerr, hold_err;
  logic [1:0] post_err_tr;

  bit dp = 1'b0;
  logic [31:0] dp_addr = 32'h0;
  int dp_beat = 0;
  int stall_beat = -1;
  int stall_left = 0;
  int err_beat = -1;
  int err_st = 0;
  logic prev_hready = 1'b1, prev_hresp = 1'b0;
  logic [1:0] prev_htrans = 2'b00;
  logic [31:0] prev_haddr = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // slave drive at negedge, then sample 1 ns later
  always @(negedge clk) begin
    I_HREADY = 1'b1;
    I_HRESP  = 1'b0;
    if (dp) begin
      I_HRDATA = 32'hC0DE_0000 | {16'h0, dp_addr[15:0]};
      if (dp_beat == err_beat && err_st < 2) begin
        I_HRESP  = 1'b1;
        I_HREADY = (err_st == 1);
        err_st++;
      end else if (dp_beat == stall_beat && stall_left > 0) begin
        I_HREADY = 1'b0;
        stall_left--;
      end
    end
    I_DMA_WDATA = 32'hA000_0000 + 32'(nwreq);
    #1;
    if (!rst_n) begin
      dp = 1'b0;
    end else begin
      if (!prev_hready && !prev_hresp && prev_htrans != 2'b00 &&
          (O_HADDR != prev_haddr || O_HTRANS != prev_htrans))
        hold_err++;
      if (prev_hresp && !prev_hready) post_err_tr = O_HTRANS;
      if (dp && I_HREADY && O_HWRITE) q_wd.push_back(O_HWDATA);
      if (O_DMA_WDATA_REQ) nwreq++;
      if (O_DMA_RDATA_VALID) q_rd.push_back(O_DMA_RDATA);
      if (O_DMA_DONE) ndone++;
      if (O_DMA_ERROR) nerr++;
      if (O_HTRANS != 2'b00 && I_HREADY) begin
        q_addr.push_back(O_HADDR);
        q_tr.push_back(O_HTRANS);
        dp = 1'b1;
        dp_addr = O_HADDR;
        dp_beat = nacc;
        nacc++;
      end else if (I_HREADY) begin
        dp = 1'b0;
      end
    end
    prev_hready = I_HREADY;
    prev_hresp  = I_HRESP;
    prev_htrans = O_HTRANS;
    prev_haddr  = O_HADDR;
  end

  task automatic clr();
    q_addr.delete();
    q_tr.delete();
    q_wd.delete();
    q_rd.delete();
    nacc = 0;
    nwreq = 0;
    ndone = 0;
    nerr = 0;
    hold_err = 0;
    post_err_tr = 2'b01;
  endtask

  task automatic run_req(input logic [31:0] a, input logic w,
                         input logic [4:0] c, input logic [2:0] s,
                         input bit poke, output int lat,
                         output logic erro);
    @(negedge clk);
    clr();
    I_DMA_ADDR  = a;
    I_DMA_WRITE = w;
    I_DMA_COUNT = c;
    I_DMA_SIZE  = s;
    I_DMA_START = 1'b1;
    lat = -1;
    erro = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) I_DMA_START = 1'b0;
      if (poke && i == 2) begin
        I_DMA_START = 1'b1;
        I_DMA_ADDR  = 32'h5000;
        I_DMA_COUNT = 5'd1;
      end
      if (poke && i == 3) I_DMA_START = 1'b0;
      #2;
      if (O_DMA_DONE) begin
        lat = i;
        erro = O_DMA_ERROR;
        break;
      end
    end
    repeat (4) @(negedge clk);
    #3;
  endtask

  initial begin
    int lat;
    logic erro;
    logic [31:0] ea;
    clr();
    repeat (2) @(negedge clk);
    #2;
    chk("rst ready", {31'h0, O_DMA_READY}, 32'h1);
    chk("rst htrans", {30'h0, O_HTRANS}, 32'h0);
    chk("rst haddr", O_HADDR, 32'h0);
    chk("rst hwdata", O_HWDATA, 32'h0);
    chk("rst rdata", O_DMA_RDATA, 32'h0);
    chk("rst hwrite", {31'h0, O_HWRITE}, 32'h0);
    chk("rst hsize", {29'h0, O_HSIZE}, 32'h2);
    chk("rst hburst", {29'h0, O_HBURST}, 32'h1);
    chk("rst done", {30'h0, O_DMA_DONE, O_DMA_ERROR}, 32'h0);
    chk("rst strobes", {30'h0, O_DMA_WDATA_REQ, O_DMA_RDATA_VALID}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // write burst, with a START poke mid-burst that must be ignored
    run_req(32'h100, 1'b1, 5'd6, 3'd2, 1'b1, lat, erro);
    chk("t1 latency", 32'(lat), 32'd7);
    chk("t1 error", {31'h0, erro}, 32'h0);
    chk("t1 beats", 32'(nacc), 32'd6);
    chk("t1 wreq", 32'(nwreq), 32'd6);
    chk("t1 done", 32'(ndone), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1 addr%0d", i),
          (i < q_addr.size()) ? q_addr[i] : 32'hxxxx_xxxx,
          32'h100 + 32'(4 * i));
      chk($sformatf("t1 htrans%0d", i),
          (i < q_tr.size()) ? {30'h0, q_tr[i]} : 32'hxxxx_xxxx,
          (i == 0) ? 32'h2 : 32'h3);
      chk($sformatf("t1 hwdata%0d", i),
          (i < q_wd.size()) ? q_wd[i] : 32'hxxxx_xxxx,
          32'hA000_0000 + 32'(i));
    end

    // read burst with two wait states on beat 3's data phase
    stall_beat = 3;
    stall_left = 2;
    run_req(32'h100, 1'b0, 5'd6, 3'd2, 1'b0, lat, erro);
    stall_beat = -1;
    chk("t2 latency", 32'(lat), 32'd9);
    chk("t2 rvalid", 32'(q_rd.size()), 32'd6);
    chk("t2 hold", 32'(hold_err), 32'd0);
    chk("t2 wreq", 32'(nwreq), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2 addr%0d", i),
          (i < q_addr.size()) ? q_addr[i] : 32'hxxxx_xxxx,
          32'h100 + 32'(4 * i));
      chk($sformatf("t2 rdata%0d", i),
          (i < q_rd.size()) ? q_rd[i] : 32'hxxxx_xxxx,
          32'hC0DE_0100 + 32'(4 * i));
    end

    // 1 KB boundary crossing
    run_req(32'h3F8, 1'b1, 5'd6, 3'd2, 1'b0, lat, erro);
    chk("t3 latency", 32'(lat), 32'd7);
    for (int i = 0; i < 6; i++) begin
      ea = 32'h3F8 + 32'(4 * i);
      chk($sformatf("t3 addr%0d", i),
          (i < q_addr.size()) ? q_addr[i] : 32'hxxxx_xxxx, ea);
      chk($sformatf("t3 htrans%0d", i),
          (i < q_tr.size()) ? {30'h0, q_tr[i]} : 32'hxxxx_xxxx,
          (i == 0 || i == 2) ? 32'h2 : 32'h3);
    end

    // error response on beat 2
    err_beat = 2;
    err_st = 0;
    run_req(32'h200, 1'b0, 5'd6, 3'd2, 1'b0, lat, erro);
    err_beat = -1;
    chk("t4 latency", 32'(lat), 32'd5);
    chk("t4 error", {31'h0, erro}, 32'h1);
    chk("t4 beats", 32'(nacc), 32'd3);
    chk("t4 rvalid", 32'(q_rd.size()), 32'd2);
    chk("t4 htrans after err", {30'h0, post_err_tr}, 32'h0);
    chk("t4 done", 32'(ndone), 32'd1);
    chk("t4 errcnt", 32'(nerr), 32'd1);

    // zero-length and illegal-size requests
    run_req(32'h300, 1'b1, 5'd0, 3'd2, 1'b0, lat, erro);
    chk("t5 c0 latency", 32'(lat), 32'd0);
    chk("t5 c0 error", {31'h0, erro}, 32'h0);
    chk("t5 c0 beats", 32'(nacc), 32'd0);
    run_req(32'h300, 1'b1, 5'd4, 3'd3, 1'b0, lat, erro);
    chk("t5 s3 latency", 32'(lat), 32'd0);
    chk("t5 s3 error", {31'h0, erro}, 32'h1);
    chk("t5 s3 beats", 32'(nacc), 32'd0);

    // reset in the middle of a burst
    @(negedge clk);
    clr();
    I_DMA_ADDR  = 32'h100;
    I_DMA_WRITE = 1'b1;
    I_DMA_COUNT = 5'd10;
    I_DMA_SIZE  = 3'd2;
    I_DMA_START = 1'b1;
    @(negedge clk);
    I_DMA_START = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("t6 busy", {31'h0, O_DMA_READY}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("t6 htrans", {30'h0, O_HTRANS}, 32'h0);
    chk("t6 haddr", O_HADDR, 32'h0);
    chk("t6 hwdata", O_HWDATA, 32'h0);
    chk("t6 ready", {31'h0, O_DMA_READY}, 32'h1);
    chk("t6 wreq", {31'h0, O_DMA_WDATA_REQ}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #3;
    chk("t6 no done", 32'(ndone), 32'd0);

    // single-beat write after reset recovery
    run_req(32'h40, 1'b1, 5'd1, 3'd0, 1'b0, lat, erro);
    chk("t7 latency", 32'(lat), 32'd2);
    chk("t7 beats", 32'(nacc), 32'd1);
    chk("t7 addr", (q_addr.size() > 0) ? q_addr[0] : 32'hxxxx_xxxx,
        32'h40);
    chk("t7 hsize", {29'h0, O_HSIZE}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
